// File: rtl/dbg_exec_ctrl_if.sv
// dbg_exec_ctrl_if: host command strobe and UART TX FIFO push port of the debug controller
interface dbg_exec_ctrl_if;
  logic       i_cmd_valid;
  logic [7:0] i_cmd;
  logic       i_tx_full;
  logic [7:0] o_tx_data;
  logic       o_tx_wr;
  modport master (output i_cmd_valid, i_cmd, i_tx_full, input o_tx_data, o_tx_wr);
  modport slave  (input i_cmd_valid, i_cmd, i_tx_full, output o_tx_data, o_tx_wr);
endinterface

// File: rtl/dbg_exec_ctrl.sv
// dbg_exec_ctrl: decodes host commands into pipeline run/step/reset and streams the state dump
module dbg_exec_ctrl #(
  parameter int NB_REG      = 32,
  parameter int NB_R_INT    = 376,
  parameter int N_REGS      = 32,
  parameter int N_MEM_WORDS = 32,
  parameter int RST_CYCLES  = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_halt,
  input  logic [NB_R_INT-1:0] i_reg_int,
  input  logic [NB_REG-1:0]   i_reg_data,
  input  logic [NB_REG-1:0]   i_mem_data,
  dbg_exec_ctrl_if.slave      bus,
  output logic                o_enable,
  output logic                o_reset_mips,
  output logic [NB_REG-1:0]   o_addr,
  output logic                o_busy,
  output logic                o_done
);
  localparam int NB_INT = NB_R_INT / 8;
  localparam int NB_WB  = NB_REG / 8;
  localparam int CW     = $clog2(NB_INT + RST_CYCLES + NB_WB + 1);
  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] RUN    = 4'd1;
  localparam logic [3:0] STEP   = 4'd2;
  localparam logic [3:0] RST    = 4'd3;
  localparam logic [3:0] D_INT  = 4'd4;
  localparam logic [3:0] D_ADDR = 4'd5;
  localparam logic [3:0] D_LOAD = 4'd6;
  localparam logic [3:0] D_BYTE = 4'd7;
  localparam logic [3:0] DONE   = 4'd8;
  logic [3:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NB_REG-1:0]   idx_q, idx_d, last_idx;
  logic                mem_q, mem_d;
  logic [NB_REG-1:0]   word_q, word_d;
  logic [NB_R_INT-1:0] shreg_q, shreg_d;
  logic                push;
  assign push         = (state_q == D_INT || state_q == D_BYTE) && !bus.i_tx_full;
  assign last_idx     = mem_q ? NB_REG'(N_MEM_WORDS - 1) : NB_REG'(N_REGS - 1);
  assign bus.o_tx_wr  = push;
  assign bus.o_tx_data = state_q == D_INT ? shreg_q[NB_R_INT-1 -: 8] : word_q[NB_REG-1 -: 8];
  // halt gates the enable combinationally so the pipeline stops in the halting cycle
  assign o_enable     = state_q == STEP || (state_q == RUN && !i_halt);
  assign o_reset_mips = state_q == RST;
  assign o_addr       = idx_q;
  assign o_busy       = state_q != IDLE;
  assign o_done       = state_q == DONE;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    word_d  = word_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE:
        if (bus.i_cmd_valid)
          state_d = bus.i_cmd == 8'h63 ? RUN :
                    bus.i_cmd == 8'h73 ? STEP :
                    bus.i_cmd == 8'h72 ? RST :
                    bus.i_cmd == 8'h64 ? D_INT : IDLE;
      RUN:  state_d = i_halt ? D_INT : RUN;
      STEP: state_d = D_INT;
      RST: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      D_INT:
        if (push) begin
          shreg_d = shreg_q << 8;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(NB_INT - 1)) begin
            cnt_d   = '0;
            state_d = D_ADDR;
          end
        end
      D_ADDR: state_d = D_LOAD;
      D_LOAD: begin
        word_d  = mem_q ? i_mem_data : i_reg_data;
        state_d = D_BYTE;
      end
      D_BYTE:
        if (push) begin
          word_d = word_q << 8;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(NB_WB - 1)) begin
            cnt_d   = '0;
            idx_d   = idx_q + NB_REG'(1);
            state_d = D_ADDR;
            if (idx_q == last_idx) begin
              idx_d = '0;
              mem_d = 1'b1;
              if (mem_q) begin
                mem_d   = 1'b0;
                state_d = DONE;
              end
            end
          end
        end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == D_INT && state_q != D_INT) shreg_d = i_reg_int;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mem_q   <= 1'b0;
      word_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mem_q   <= mem_d;
      word_q  <= word_d;
      shreg_q <= shreg_d;
    end
  end
endmodule

// File: tb/tb_dbg_exec_ctrl.sv
// tb_dbg_exec_ctrl: directed checks of command decode, run/step/reset control and dump byte stream
module tb_dbg_exec_ctrl;
  localparam int NBYTES = 303;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         halt = 1'b0;
  logic [375:0] snap;
  logic [31:0]  reg_data = '0, mem_data = '0, addr;
  logic         en, rstm, busy, done;
  logic [31:0]  regs [32];
  logic [31:0]  mem  [32];
  logic [7:0]   exp_b [NBYTES];
  logic [7:0]   cap [4096];
  int wr_cnt = 0, wr_full = 0, en_cnt = 0, rstm_cnt = 0, done_cnt = 0;
  int checks = 0, failures = 0;
  int w0, e0, d0, r0, w1;
  dbg_exec_ctrl_if bus();
  dbg_exec_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_halt(halt), .i_reg_int(snap),
    .i_reg_data(reg_data), .i_mem_data(mem_data), .bus(bus.slave),
    .o_enable(en), .o_reset_mips(rstm), .o_addr(addr), .o_busy(busy), .o_done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    reg_data <= regs[addr[4:0]];
    mem_data <= mem[addr[4:0]];
  end
  always @(posedge clk) begin
    if (bus.o_tx_wr) begin
      if (wr_cnt < 4096) cap[wr_cnt] = bus.o_tx_data;
      wr_cnt++;
      if (bus.i_tx_full) wr_full++;
    end
    en_cnt   += int'(en);
    rstm_cnt += int'(rstm);
    done_cnt += int'(done);
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  function automatic int dump_errs(input int base);
    int e = 0;
    for (int k = 0; k < NBYTES; k++)
      if (base + k >= 4096 || cap[base + k] !== exp_b[k]) e++;
    return e;
  endfunction
  function automatic logic [31:0] word_at(input int idx);
    return {cap[idx], cap[idx+1], cap[idx+2], cap[idx+3]};
  endfunction
  task automatic send(input logic [7:0] c);
    @(negedge clk);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd = c;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = 8'h00;
  endtask
  task automatic wait_done(input int dref, input bit bp);
    int n = 0;
    while (done_cnt == dref && n < 3000) begin
      @(negedge clk);
      if (bp) bus.i_tx_full = 1'($urandom_range(0, 1));
      n++;
    end
    bus.i_tx_full = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    for (int k = 0; k < 47; k++) snap[375 - 8*k -: 8] = k == 0 ? 8'hA5 : 8'(k * 7 + 3);
    for (int i = 0; i < 32; i++) begin
      regs[i] = i == 1 ? 32'h11223344 : (32'h01010101 * i) ^ 32'hC0DE0000;
      mem[i]  = i == 0 ? 32'hDEADBEEF : 32'h10000000 + 32'(i * 3);
    end
    for (int k = 0; k < 47; k++) exp_b[k] = snap[375 - 8*k -: 8];
    for (int w = 0; w < 32; w++)
      for (int b = 0; b < 4; b++) begin
        exp_b[47 + 4*w + b]  = regs[w][31 - 8*b -: 8];
        exp_b[175 + 4*w + b] = mem[w][31 - 8*b -: 8];
      end
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = 8'h00;
    bus.i_tx_full = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_outputs", {en, rstm, busy, done, bus.o_tx_wr, bus.o_tx_data, addr}, 0);
    w0 = wr_cnt; e0 = en_cnt; d0 = done_cnt;
    send(8'h73);
    wait_done(d0, 1'b0);
    check("step_enable_cycles", en_cnt - e0, 1);
    check("step_writes", wr_cnt - w0, NBYTES);
    check("step_dump_errs", dump_errs(w0), 0);
    check("step_first_byte", cap[w0], 8'hA5);
    check("step_r1_bytes", word_at(w0 + 51), 32'h11223344);
    check("step_mem0_bytes", word_at(w0 + 175), 32'hDEADBEEF);
    check("step_done_pulses", done_cnt - d0, 1);
    check("step_busy_after", busy, 0);
    w0 = wr_cnt; e0 = en_cnt; d0 = done_cnt;
    send(8'h63);
    repeat (10) @(negedge clk);
    halt = 1'b1;
    #1;
    check("run_halt_gate", {en, busy}, 2'b01);
    wait_done(d0, 1'b0);
    check("run_enable_cycles", en_cnt - e0, 10);
    check("run_writes", wr_cnt - w0, NBYTES);
    check("run_dump_errs", dump_errs(w0), 0);
    check("run_done_pulses", done_cnt - d0, 1);
    w0 = wr_cnt; e0 = en_cnt; d0 = done_cnt;
    send(8'h63);
    wait_done(d0, 1'b0);
    halt = 1'b0;
    check("run_halted_enable", en_cnt - e0, 0);
    check("run_halted_writes", wr_cnt - w0, NBYTES);
    check("run_halted_done", done_cnt - d0, 1);
    w0 = wr_cnt; d0 = done_cnt; r0 = rstm_cnt; e0 = en_cnt;
    send(8'h72);
    repeat (10) @(negedge clk);
    check("rst_cycles", rstm_cnt - r0, 4);
    check("rst_no_writes_enable", {wr_cnt - w0, en_cnt - e0}, 0);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_busy_after", busy, 0);
    send(8'h55);
    check("bad_cmd_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("bad_cmd_no_activity", {wr_cnt - w0, en_cnt - e0, rstm_cnt - r0 - 4, done_cnt - d0}, 0);
    w0 = wr_cnt; d0 = done_cnt; w1 = wr_full;
    send(8'h64);
    wait_done(d0, 1'b1);
    check("bp_writes", wr_cnt - w0, NBYTES);
    check("bp_dump_errs", dump_errs(w0), 0);
    check("bp_write_while_full", wr_full - w1, 0);
    check("bp_done_pulses", done_cnt - d0, 1);
    w0 = wr_cnt; d0 = done_cnt; e0 = en_cnt;
    send(8'h64);
    repeat (20) @(negedge clk);
    send(8'h73);
    wait_done(d0, 1'b0);
    repeat (10) @(negedge clk);
    check("filter_no_enable", en_cnt - e0, 0);
    check("filter_done_pulses", done_cnt - d0, 1);
    check("filter_writes", wr_cnt - w0, NBYTES);
    check("filter_dump_errs", dump_errs(w0), 0);
    w0 = wr_cnt; d0 = done_cnt;
    send(8'h64);
    for (int n = 0; n < 1000 && wr_cnt - w0 < 100; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {en, rstm, busy, done, bus.o_tx_wr, addr}, 0);
    rst = 1'b0;
    w1 = wr_cnt;
    repeat (10) @(negedge clk);
    check("midreset_aborted", {wr_cnt - w1, done_cnt - d0}, 0);
    w0 = wr_cnt;
    send(8'h64);
    wait_done(d0, 1'b0);
    check("restart_first_byte", cap[w0], 8'hA5);
    check("restart_writes", wr_cnt - w0, NBYTES);
    check("restart_dump_errs", dump_errs(w0), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
